// File: rtl/div_sweep_ctrl_if.sv
// Handshake and signal bundle between a sweep master (configuration side) and div_sweep_ctrl.
// The divider output and the halfdivisor word also travel here so the controller has one bus port.
interface div_sweep_ctrl_if #(
  parameter int NUM_DIVISOR_BITS = 4,
  parameter int DWELL_BITS       = 8
);
  logic                        cfg_valid;
  logic                        cfg_ready;
  logic [NUM_DIVISOR_BITS-1:0] cfg_start;
  logic [NUM_DIVISOR_BITS-1:0] cfg_stop;
  logic [NUM_DIVISOR_BITS-1:0] cfg_step;
  logic [DWELL_BITS-1:0]       cfg_dwell;
  logic                        cfg_cont;
  logic                        abort;
  logic                        div_out;
  logic [NUM_DIVISOR_BITS-1:0] halfdivisor;
  logic                        busy;
  logic                        done;
  logic                        aborted;

  modport master (
    output cfg_valid, cfg_start, cfg_stop, cfg_step, cfg_dwell, cfg_cont, abort, div_out,
    input  cfg_ready, halfdivisor, busy, done, aborted
  );

  modport slave (
    input  cfg_valid, cfg_start, cfg_stop, cfg_step, cfg_dwell, cfg_cont, abort, div_out,
    output cfg_ready, halfdivisor, busy, done, aborted
  );
endinterface

// File: rtl/div_sweep_ctrl.sv
// Sweep sequencer for the PLL feedback divider: ramps halfdivisor from start to stop,
// updating it only right after a divider output rising edge so the divider reloads a stable word.
module div_sweep_ctrl #(
  parameter int                          NUM_DIVISOR_BITS = 4,
  parameter int                          DWELL_BITS       = 8,
  parameter logic [NUM_DIVISOR_BITS-1:0] DEFAULT_HALFDIV  = 4'd3
) (
  input  logic              clk,
  input  logic              reset,
  div_sweep_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    DWELL = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                      r_state;
  logic [NUM_DIVISOR_BITS-1:0] r_halfdiv;
  logic [NUM_DIVISOR_BITS-1:0] r_start;
  logic [NUM_DIVISOR_BITS-1:0] r_stop;
  logic [NUM_DIVISOR_BITS-1:0] r_step;
  logic [DWELL_BITS-1:0]       r_dwell;
  logic [DWELL_BITS-1:0]       r_cnt;
  logic                        r_cont;
  logic                        r_up;
  logic                        r_ready;
  logic                        r_busy;
  logic                        r_done;
  logic                        r_aborted;
  logic                        r_sync1;
  logic                        r_sync2;
  logic                        r_hist;

  logic                        w_edge;
  logic [DWELL_BITS-1:0]       w_effDwell;
  logic                        w_atEnd;
  logic [NUM_DIVISOR_BITS-1:0] w_nextFwd;
  logic [NUM_DIVISOR_BITS-1:0] w_nextRev;

  // Moves one step toward target, clamping at target; compares with an extra bit so nothing wraps.
  function automatic logic [NUM_DIVISOR_BITS-1:0] towards(
    input logic [NUM_DIVISOR_BITS-1:0] cur,
    input logic [NUM_DIVISOR_BITS-1:0] step,
    input logic [NUM_DIVISOR_BITS-1:0] target,
    input logic                        up
  );
    logic [NUM_DIVISOR_BITS:0] sum;
    sum = {1'b0, cur} + {1'b0, step};
    if (up) begin
      towards = (sum >= {1'b0, target}) ? target : sum[NUM_DIVISOR_BITS-1:0];
    end else begin
      towards = ({1'b0, cur} <= ({1'b0, target} + {1'b0, step})) ? target : (cur - step);
    end
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= 1'b0;
    end else begin
      r_sync1 <= bus.div_out;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  assign w_edge     = r_sync2 & ~r_hist;
  assign w_effDwell = (r_dwell == '0) ? DWELL_BITS'(1) : r_dwell;
  assign w_atEnd    = (r_halfdiv == r_stop) || (r_step == '0);
  assign w_nextFwd  = towards(r_halfdiv, r_step, r_stop, r_up);
  assign w_nextRev  = towards(r_halfdiv, r_step, r_start, ~r_up);

  // Main sequencer; abort outranks an edge arriving in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_halfdiv <= DEFAULT_HALFDIV;
      r_start   <= '0;
      r_stop    <= '0;
      r_step    <= '0;
      r_dwell   <= '0;
      r_cnt     <= '0;
      r_cont    <= 1'b0;
      r_up      <= 1'b1;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.cfg_valid && r_ready) begin
            r_start <= bus.cfg_start;
            r_stop  <= bus.cfg_stop;
            r_step  <= bus.cfg_step;
            r_dwell <= bus.cfg_dwell;
            r_cont  <= bus.cfg_cont;
            r_up    <= (bus.cfg_start <= bus.cfg_stop);
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ARM;
          end
        end
        ARM: begin
          if (bus.abort) begin
            r_aborted <= 1'b1;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= IDLE;
          end else if (w_edge) begin
            r_halfdiv <= r_start;
            r_cnt     <= w_effDwell;
            r_state   <= DWELL;
          end
        end
        DWELL: begin
          if (bus.abort) begin
            r_aborted <= 1'b1;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= IDLE;
          end else if (w_edge) begin
            if (r_cnt > DWELL_BITS'(1)) begin
              r_cnt <= r_cnt - DWELL_BITS'(1);
            end else if (w_atEnd && !r_cont) begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end else if (w_atEnd) begin
              // Turnaround: the original start becomes the new target.
              r_start   <= r_stop;
              r_stop    <= r_start;
              r_up      <= ~r_up;
              r_halfdiv <= w_nextRev;
              r_cnt     <= w_effDwell;
            end else begin
              r_halfdiv <= w_nextFwd;
              r_cnt     <= w_effDwell;
            end
          end
        end
        DONE: begin
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.cfg_ready   = r_ready;
  assign bus.halfdivisor = r_halfdiv;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.aborted     = r_aborted;

endmodule

// File: tb/tb_div_sweep_ctrl.sv
// Self-checking bench for div_sweep_ctrl: directed and random sweeps compared against
// a value-list model of the ramp, sampled one clk either side of each expected update.
module tb_div_sweep_ctrl;
  localparam int NB = 4;
  localparam int DB = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  div_sweep_ctrl_if #(.NUM_DIVISOR_BITS(NB), .DWELL_BITS(DB)) bus ();

  div_sweep_ctrl #(.NUM_DIVISOR_BITS(NB), .DWELL_BITS(DB), .DEFAULT_HALFDIV(4'd3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;
  int lastVal = 3;
  int seq[$];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, wanted %0d", tag, actual, expected);
    end
  endtask

  // Ordered list of values the ramp visits, built from plain integer arithmetic.
  function automatic void buildSeq(input int s, input int stp, input int st, input int cont);
    int cur, tgt, other, t;
    seq.delete();
    cur = s;
    tgt = stp;
    other = s;
    seq.push_back(cur);
    while (seq.size() < 64) begin
      if (cur == tgt || st == 0) begin
        if (cont == 0) break;
        t = tgt;
        tgt = other;
        other = t;
      end
      if (cur < tgt) cur = (cur + st > tgt) ? tgt : cur + st;
      else if (cur > tgt) cur = (cur - st < tgt) ? tgt : cur - st;
      seq.push_back(cur);
    end
  endfunction

  task automatic applyStimulus(input int s, input int stp, input int st, input int dw, input int cont,
                               input int nEdges, input int abortEdge, input int holdValid);
    int de, m, doneEdge, expPrev, expNow, idx, edges;
    bit ended, abortNow, doneNow;
    de = (dw == 0) ? 1 : dw;
    buildSeq(s, stp, st, cont);
    m = seq.size();
    doneEdge = (cont != 0) ? -1 : de * m;
    edges = (nEdges < 0) ? doneEdge + 2 : nEdges;

    @(negedge clk);
    checkOutput("ready_idle", bus.cfg_ready, 1);
    bus.cfg_start = NB'(s);
    bus.cfg_stop  = NB'(stp);
    bus.cfg_step  = NB'(st);
    bus.cfg_dwell = DB'(dw);
    bus.cfg_cont  = cont[0];
    bus.cfg_valid = 1'b1;
    @(negedge clk);
    checkOutput("busy_after_cfg", bus.busy, 1);
    if (holdValid != 0) begin
      bus.cfg_start = NB'(s + 5);
      bus.cfg_stop  = NB'(stp + 3);
      bus.cfg_step  = NB'(st + 1);
    end else begin
      bus.cfg_valid = 1'b0;
    end

    expPrev = lastVal;
    ended = 1'b0;
    for (int k = 0; k < edges; k++) begin
      bus.div_out = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("hold_before_edge", bus.halfdivisor, expPrev);
      abortNow = (k == abortEdge) && !ended;
      if (k == abortEdge) begin
        bus.abort = 1'b1;
        bus.cfg_valid = 1'b0;
      end
      @(negedge clk);
      bus.abort = 1'b0;
      doneNow = 1'b0;
      if (ended || abortNow) begin
        expNow = expPrev;
      end else begin
        idx = k / de;
        if (idx >= m) idx = m - 1;
        expNow = seq[idx];
        doneNow = (k == doneEdge);
      end
      checkOutput("value_after_edge", bus.halfdivisor, expNow);
      checkOutput("done_pulse", bus.done, doneNow);
      checkOutput("aborted_pulse", bus.aborted, abortNow);
      checkOutput("cfg_ready", bus.cfg_ready, (ended || abortNow) ? 1 : 0);
      if (doneNow || abortNow) ended = 1'b1;
      expPrev = expNow;
      repeat (5) @(negedge clk);
      checkOutput("stable_mid", bus.halfdivisor, expNow);
      bus.div_out = 1'b0;
      repeat (8) @(negedge clk);
    end
    lastVal = expPrev;
    if (ended) checkOutput("busy_end", bus.busy, 0);
  endtask

  initial begin
    int s, stp, st, dw, cont, n;
    bus.cfg_valid = 1'b0;
    bus.cfg_start = '0;
    bus.cfg_stop  = '0;
    bus.cfg_step  = '0;
    bus.cfg_dwell = '0;
    bus.cfg_cont  = 1'b0;
    bus.abort     = 1'b0;
    bus.div_out   = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_halfdiv", bus.halfdivisor, 3);
    checkOutput("reset_ready", bus.cfg_ready, 1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("init_busy", bus.busy, 0);
    checkOutput("init_done", bus.done, 0);
    checkOutput("init_aborted", bus.aborted, 0);

    applyStimulus(2, 8, 3, 2, 0, -1, -1, 0);
    applyStimulus(9, 3, 4, 1, 0, -1, -1, 0);
    applyStimulus(2, 4, 2, 1, 1, 9, 7, 1);

    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    @(negedge clk);
    checkOutput("idle_abort_ignored", bus.aborted, 0);
    checkOutput("idle_abort_busy", bus.busy, 0);

    applyStimulus(5, 12, 2, 3, 0, 4, -1, 0);
    reset = 1'b0;
    #1;
    checkOutput("async_reset_halfdiv", bus.halfdivisor, 3);
    checkOutput("async_reset_busy", bus.busy, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_reset", bus.cfg_ready, 1);
    lastVal = 3;

    applyStimulus(7, 7, 0, 0, 0, -1, -1, 0);

    for (int it = 0; it < 10; it++) begin
      s    = int'($urandom_range(0, 15));
      stp  = int'($urandom_range(0, 15));
      st   = int'($urandom_range(0, 5));
      dw   = int'($urandom_range(0, 3));
      cont = int'($urandom_range(0, 1));
      if (cont != 0) begin
        n = int'($urandom_range(3, 12));
        applyStimulus(s, stp, st, dw, 1, n, n - 1, 0);
      end else begin
        applyStimulus(s, stp, st, dw, 0, -1, -1, 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
